move_sequencer: RTL and testbench

//   Game controller for the 4x4 2048 board. On a direction request it walks
//   the 16 box registers one line at a time through a single shared

---
 rtl/game2048_pkg.sv | 41 ++++
 rtl/move_sequencer_line_merge.sv | 59 +++++
 rtl/move_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_move_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game2048_pkg.sv
// Shared definitions for the 2048 game controller.
//   tile_t      : one tile, stored as a log2 exponent (0 = empty)
//   state_e     : move_sequencer FSM states (encodings are visible on the state port)
//   DIR_*       : bit positions inside the one-hot direction request
//   tile_idx/tile_row/tile_col : conversions between linear index and (row, col)
package game2048_pkg;

  localparam int unsigned TILE_W = 4;
  localparam int unsigned NTILES = 16;

  typedef logic [TILE_W-1:0] tile_t;

  localparam tile_t EMPTY = 4'd0;

  localparam int unsigned DIR_RIGHT = 0;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_UP    = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LINE  = 3'd2,
    S_SPAWN = 3'd3,
    S_WRITE = 3'd4,
    S_CHECK = 3'd5
  } state_e;

  function automatic logic [3:0] tile_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  function automatic logic [1:0] tile_row(input logic [3:0] idx);
    return idx[3:2];
  endfunction

  function automatic logic [1:0] tile_col(input logic [3:0] idx);
    return idx[1:0];
  endfunction

endpackage

// File: rtl/move_sequencer_line_merge.sv
// line_merge: combinational slide-and-merge of one 4-tile line.
//   line_i : 4 tiles, element k at [4k+3:4k]; element 0 is the destination edge
//   line_o : merged line, same packing, zero padded
module line_merge
  import game2048_pkg::*;
(
  input  logic [15:0] line_i,
  output logic [15:0] line_o
);

  tile_t      in_t [4];
  tile_t      cmp  [4];
  tile_t      res  [4];
  logic [1:0] wr;

  function automatic tile_t bump(input tile_t t);
    return (t == 4'hF) ? t : t + 4'd1;
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      in_t[k] = line_i[4*k +: 4];
      cmp[k]  = EMPTY;
    end
    // Compact nonzero tiles toward element 0.
    wr = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (in_t[k] != EMPTY) begin
        cmp[wr] = in_t[k];
        wr      = wr + 2'd1;
      end
    end
    // After compaction only these pairings are possible; the first pair to
    // match consumes its partner so a merged tile never merges again.
    res = cmp;
    if (cmp[0] != EMPTY && cmp[0] == cmp[1]) begin
      res[0] = bump(cmp[0]);
      if (cmp[2] != EMPTY && cmp[2] == cmp[3]) begin
        res[1] = bump(cmp[2]);
        res[2] = EMPTY;
      end else begin
        res[1] = cmp[2];
        res[2] = cmp[3];
      end
      res[3] = EMPTY;
    end else if (cmp[1] != EMPTY && cmp[1] == cmp[2]) begin
      res[1] = bump(cmp[1]);
      res[2] = cmp[3];
      res[3] = EMPTY;
    end else if (cmp[2] != EMPTY && cmp[2] == cmp[3]) begin
      res[2] = bump(cmp[2]);
      res[3] = EMPTY;
    end
    for (int unsigned k = 0; k < 4; k++) begin
      line_o[4*k +: 4] = res[k];
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: 2048 game controller. Walks the board one line per cycle
// through a shared line_merge, spawns a tile, writes the board back.
//   clock, resetn         : clock / async active-low reset
//   dir_valid, direction  : move request, one-hot {up,down,left,right}
//   board_in              : current board, tile i at [63-4i -: 4]
//   board_out, board_we   : new board and its one-cycle write enable
//   busy                  : high whenever not idle
//   endstatus             : 00 playing, 01 won, 10 lost (sticky)
//   state                 : FSM state encoding
module move_sequencer
  import game2048_pkg::*;
#(
  parameter int unsigned WIN_EXP   = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        dir_valid,
  input  logic [3:0]  direction,
  input  logic [63:0] board_in,
  output logic [63:0] board_out,
  output logic        board_we,
  output logic        busy,
  output logic [1:0]  endstatus,
  output logic [2:0]  state
);

  localparam tile_t WIN_TILE = tile_t'(WIN_EXP);

  state_e      state_q, state_d;
  tile_t       work_q [NTILES];
  tile_t       work_d [NTILES];
  logic [1:0]  line_q, line_d;
  logic        moved_q, moved_d;
  logic [3:0]  dir_q, dir_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  spawn_cnt_q, spawn_cnt_d;
  logic [1:0]  endstatus_q, endstatus_d;
  logic [63:0] board_out_q;
  logic        board_we_q;

  logic        accept;
  logic [3:0]  line_idx [4];
  logic [15:0] merge_in, merge_out;
  logic        line_changed;
  logic [3:0]  probe, spawn_idx, ci;
  logic        spawn_found;
  tile_t       spawn_val;
  logic        any_win, any_empty, any_pair;
  logic [63:0] work_packed_d;

  line_merge u_line_merge (
    .line_i (merge_in),
    .line_o (merge_out)
  );

  assign accept       = (state_q == S_IDLE) && dir_valid && $onehot(direction) &&
                        (endstatus_q == 2'b00);
  assign line_changed = (merge_in != merge_out);
  assign lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign spawn_val    = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;

  // Line gather: element 0 is the tile on the destination edge.
  always_comb begin
    merge_in = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      case (1'b1)
        dir_q[DIR_LEFT]:  line_idx[k] = tile_idx(line_q, 2'(k));
        dir_q[DIR_RIGHT]: line_idx[k] = tile_idx(line_q, 2'(3 - k));
        dir_q[DIR_UP]:    line_idx[k] = tile_idx(2'(k), line_q);
        dir_q[DIR_DOWN]:  line_idx[k] = tile_idx(2'(3 - k), line_q);
        default:          line_idx[k] = tile_idx(line_q, 2'(k));
      endcase
      merge_in[4*k +: 4] = work_q[line_idx[k]];
    end
  end

  // Rotated priority search: first empty cell at or after lfsr[3:0].
  always_comb begin
    spawn_found = 1'b0;
    spawn_idx   = '0;
    probe       = '0;
    for (int unsigned off = 0; off < NTILES; off++) begin
      probe = lfsr_q[3:0] + 4'(off);
      if (!spawn_found && work_q[probe] == EMPTY) begin
        spawn_found = 1'b1;
        spawn_idx   = probe;
      end
    end
  end

  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    ci        = '0;
    for (int unsigned i = 0; i < NTILES; i++) begin
      ci = 4'(i);
      if (work_q[ci] >= WIN_TILE) any_win = 1'b1;
      if (work_q[ci] == EMPTY) any_empty = 1'b1;
      if (tile_col(ci) != 2'd3 && work_q[ci] == work_q[ci + 4'd1]) any_pair = 1'b1;
      if (tile_row(ci) != 2'd3 && work_q[ci] == work_q[ci + 4'd4]) any_pair = 1'b1;
    end
  end

  // Datapath next-state.
  always_comb begin
    work_d      = work_q;
    line_d      = line_q;
    moved_d     = moved_q;
    dir_d       = dir_q;
    spawn_cnt_d = spawn_cnt_q;
    endstatus_d = endstatus_q;
    case (state_q)
      S_IDLE: if (accept) dir_d = direction;
      S_LOAD: begin
        for (int unsigned i = 0; i < NTILES; i++) work_d[i] = board_in[63 - 4*i -: 4];
        line_d      = '0;
        moved_d     = 1'b0;
        spawn_cnt_d = 2'd1;
      end
      S_LINE: begin
        for (int unsigned k = 0; k < 4; k++) work_d[line_idx[k]] = merge_out[4*k +: 4];
        if (line_changed) moved_d = 1'b1;
        line_d = line_q + 2'd1;
      end
      S_SPAWN: begin
        if (spawn_found) work_d[spawn_idx] = spawn_val;
        if (spawn_cnt_q != 2'd0) spawn_cnt_d = spawn_cnt_q - 2'd1;
      end
      S_CHECK: begin
        if (endstatus_q == 2'b00) begin
          if (any_win) endstatus_d = 2'b01;
          else if (!any_empty && !any_pair) endstatus_d = 2'b10;
        end
      end
      default: ;
    endcase
    for (int unsigned i = 0; i < NTILES; i++) work_packed_d[63 - 4*i -: 4] = work_d[i];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_SPAWN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_LINE;
      S_LINE:  if (line_q == 2'd3) state_d = (moved_q || line_changed) ? S_SPAWN : S_IDLE;
      S_SPAWN: if (spawn_cnt_q <= 2'd1) state_d = S_WRITE;
      S_WRITE: state_d = S_CHECK;
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    state     = state_q;
    board_we  = board_we_q;
    board_out = board_out_q;
    endstatus = endstatus_q;
  end

  // board_out and board_we are loaded on entry to WRITE so both are valid
  // together for the whole WRITE cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NTILES; i++) work_q[i] <= EMPTY;
      line_q      <= '0;
      moved_q     <= 1'b0;
      dir_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      spawn_cnt_q <= 2'd2;
      endstatus_q <= '0;
      board_out_q <= '0;
      board_we_q  <= 1'b0;
    end else begin
      work_q      <= work_d;
      line_q      <= line_d;
      moved_q     <= moved_d;
      dir_q       <= dir_d;
      lfsr_q      <= lfsr_d;
      spawn_cnt_q <= spawn_cnt_d;
      endstatus_q <= endstatus_d;
      board_we_q  <= (state_d == S_WRITE);
      if (state_d == S_WRITE) board_out_q <= work_packed_d;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [3:0] D_UP = 4'b1000, D_DOWN = 4'b0100, D_LEFT = 4'b0010, D_RIGHT = 4'b0001;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        dir_valid = 1'b0;
  logic [3:0]  direction = '0;
  logic [63:0] board_in;
  logic [63:0] board_out;
  logic        board_we, busy;
  logic [1:0]  endstatus;
  logic [2:0]  state;

  move_sequencer #(.WIN_EXP(11), .LFSR_SEED(SEED)) dut (
    .clock(clock), .resetn(resetn), .dir_valid(dir_valid), .direction(direction),
    .board_in(board_in), .board_out(board_out), .board_we(board_we), .busy(busy),
    .endstatus(endstatus), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct { logic [63:0] board; logic [1:0] endst; } exp_t;
  exp_t        sb[$];
  int          checks = 0, errors = 0;
  int          mb[16];
  int          eb[16];
  logic [1:0]  exp_end = 2'b00;
  logic [15:0] m_lfsr;
  logic [63:0] board_drv = '0;
  int          end_cd = 0;
  logic [1:0]  end_exp = 2'b00;

  assign board_in = board_drv;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  always @(posedge clock or negedge resetn)
    if (!resetn) m_lfsr <= SEED;
    else         m_lfsr <= lstep(m_lfsr);

  function automatic logic [63:0] pack_arr(input int a[16]);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[63 - 4*i -: 4] = 4'(a[i]);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic set_board();
    board_drv = pack_arr(mb);
  endtask

  task automatic spawn_one(input logic [15:0] l);
    int s, j;
    s = int'(l[3:0]);
    for (int off = 0; off < 16; off++) begin
      j = (s + off) % 16;
      if (eb[j] == 0) begin
        eb[j] = (l[7:4] == 4'd0) ? 2 : 1;
        return;
      end
    end
  endtask

  // Slide each line toward the destination edge, merging equal pairs once.
  task automatic apply_move(input logic [3:0] d, output bit moved);
    int pos[4];
    int res[4];
    int q[$];
    int a, n;
    moved = 0;
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 4; k++) begin
        if (d == D_LEFT)       pos[k] = l*4 + k;
        else if (d == D_RIGHT) pos[k] = l*4 + 3 - k;
        else if (d == D_UP)    pos[k] = k*4 + l;
        else                   pos[k] = (3 - k)*4 + l;
      end
      q.delete();
      for (int k = 0; k < 4; k++) if (mb[pos[k]] != 0) q.push_back(mb[pos[k]]);
      for (int k = 0; k < 4; k++) res[k] = 0;
      n = 0;
      while (q.size() > 0) begin
        a = q.pop_front();
        if (q.size() > 0 && q[0] == a) begin
          void'(q.pop_front());
          a = (a < 15) ? a + 1 : 15;
        end
        res[n] = a;
        n++;
      end
      for (int k = 0; k < 4; k++) begin
        eb[pos[k]] = res[k];
        if (res[k] != mb[pos[k]]) moved = 1;
      end
    end
  endtask

  task automatic update_end();
    bit win, empty, pair;
    win = 0; empty = 0; pair = 0;
    if (exp_end != 2'b00) return;
    for (int i = 0; i < 16; i++) begin
      if (eb[i] >= 11) win = 1;
      if (eb[i] == 0) empty = 1;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) begin
        if (eb[r*4 + c] == eb[r*4 + c + 1]) pair = 1;
        if (eb[c*4 + r] == eb[(c + 1)*4 + r]) pair = 1;
      end
    if (win) exp_end = 2'b01;
    else if (!empty && !pair) exp_end = 2'b10;
  endtask

  // Called just after a negedge with the DUT idle.
  task automatic issue(input logic [3:0] d, input bit poke);
    bit acc, moved;
    int cyc;
    logic [15:0] l;
    exp_t e;
    acc   = ($countones(d) == 1) && (exp_end == 2'b00);
    moved = 0;
    if (acc) begin
      apply_move(d, moved);
      if (moved) begin
        l = m_lfsr;
        repeat (6) l = lstep(l);
        spawn_one(l);
        update_end();
        e.board = pack_arr(eb);
        e.endst = exp_end;
        sb.push_back(e);
      end
    end
    dir_valid = 1'b1;
    direction = d;
    @(negedge clock);
    dir_valid = 1'b0;
    cyc = 1;
    if (!acc) begin
      check("ignored_request", 64'(busy), 64'(0));
      return;
    end
    while (busy && cyc < 40) begin
      if (poke && cyc == 3) begin
        dir_valid = 1'b1;
        direction = D_LEFT;
      end else dir_valid = 1'b0;
      @(negedge clock);
      cyc++;
      if (board_we) check("we_cycle", 64'(cyc), 64'(7));
    end
    dir_valid = 1'b0;
    check(moved ? "move_latency" : "nomove_latency", 64'(cyc), moved ? 64'(9) : 64'(6));
    if (moved) begin
      for (int i = 0; i < 16; i++) mb[i] = eb[i];
      set_board();
    end
  endtask

  task automatic do_reset();
    exp_t e;
    logic [2:0] seq [4];
    seq = '{3'd3, 3'd4, 3'd5, 3'd0};
    #2;
    resetn    = 1'b0;
    dir_valid = 1'b0;
    sb.delete();
    exp_end = 2'b00;
    @(negedge clock);
    check("rst_we", 64'(board_we), 64'(0));
    check("rst_out", board_out, 64'(0));
    check("rst_state", 64'(state), 64'(3));
    check("rst_end", 64'(endstatus), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 16; i++) eb[i] = 0;
    spawn_one(SEED);
    spawn_one(lstep(SEED));
    update_end();
    e.board = pack_arr(eb);
    e.endst = exp_end;
    sb.push_back(e);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("rst_seq", 64'(state), 64'(seq[k]));
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 16; i++) mb[i] = 0;
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (!resetn) end_cd = 0;
    else begin
      if (end_cd > 0) begin
        end_cd--;
        if (end_cd == 0) check("endstatus", 64'(endstatus), 64'(end_exp));
      end
      if (board_we) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_we: got board_we=1 with board %h, required no write", board_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks--;
          check("board_out", board_out, e.board);
          end_exp = e.endst;
          end_cd  = 2;
        end
      end
    end
  end

  initial begin
    int lose_b[16];
    lose_b = '{0, 3, 4, 5, 6, 7, 8, 9, 3, 4, 5, 6, 7, 8, 9, 10};

    clear_board();
    set_board();
    do_reset();

    // Single merge per pair.
    clear_board(); mb[0] = 1; mb[1] = 1; mb[2] = 2; set_board();
    issue(D_LEFT, 0);
    // Four equal tiles, both directions.
    clear_board(); mb[0] = 1; mb[1] = 1; mb[2] = 1; mb[3] = 1; set_board();
    issue(D_LEFT, 0);
    clear_board(); mb[0] = 1; mb[1] = 1; mb[2] = 1; mb[3] = 1; set_board();
    issue(D_RIGHT, 0);
    clear_board(); mb[0] = 1; mb[12] = 1; set_board();
    issue(D_UP, 0);
    clear_board(); mb[0] = 15; mb[4] = 15; set_board();
    issue(D_DOWN, 0);
    // Packed board, nothing moves.
    clear_board(); mb[0] = 1; mb[1] = 2; mb[4] = 3; set_board();
    issue(D_LEFT, 0);
    issue(D_LEFT, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++)
        mb[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
      set_board();
      issue(4'b0001 << $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end

    // Lose: one empty cell filled by the spawn, no merges left.
    do_reset();
    clear_board(); mb[1] = 2; set_board();
    issue(4'b0011, 0);
    issue(4'b0000, 0);
    for (int i = 0; i < 16; i++) mb[i] = lose_b[i];
    set_board();
    issue(D_LEFT, 1);
    issue(D_UP, 0);

    // Win, then requests are ignored.
    do_reset();
    clear_board(); mb[0] = 10; mb[1] = 10; set_board();
    issue(D_LEFT, 0);
    issue(D_RIGHT, 0);

    // Reset in the middle of LINE aborts the move.
    do_reset();
    clear_board(); mb[1] = 1; set_board();
    dir_valid = 1'b1; direction = D_LEFT;
    @(negedge clock); dir_valid = 1'b0;
    @(negedge clock);
    check("mid_line_state", 64'(state), 64'(2));
    do_reset();
    clear_board(); mb[5] = 3; mb[6] = 3; set_board();
    issue(D_RIGHT, 0);

    repeat (5) @(negedge clock);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
